// File: rtl/ice_sl_arbiter_pkg.sv
// Shared types for the ICE slave-bus arbiter: FSM encoding, abort counter limits, index wrap helper.
package ice_sl_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam int ABORT_CNT_W = 8;
  localparam logic [ABORT_CNT_W-1:0] ABORT_CNT_MAX = 8'hFF;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ice_sl_arbiter_if.sv
// Request/grant bundle between the interface blocks (master) and the sl_* bus arbiter (slave).
interface ice_sl_arbiter_if #(
  parameter int NUM_DEV = 7,
  parameter int IDX_W   = 3
);
  logic [NUM_DEV-1:0] sl_arb_request;
  logic [NUM_DEV-1:0] sl_arb_grant;
  logic               sl_busy;
  logic [IDX_W-1:0]   sl_owner;

  modport master (output sl_arb_request, input sl_arb_grant, input sl_busy, input sl_owner);
  modport slave  (input sl_arb_request, output sl_arb_grant, output sl_busy, output sl_owner);
endinterface

// File: rtl/ice_sl_arbiter_pick.sv
// Combinational winner selection over the eligible set: lowest index (fixed) or first at/after rr_ptr.
// Zero latency; no flow control of its own.
module ice_sl_arbiter_pick
  import ice_sl_arbiter_pkg::*;
#(
  parameter int NUM_DEV = 7,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_DEV-1:0] elig,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic               prio_mode,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = prio_mode ? int'(rr_ptr) : 0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (!found && elig[IDX_W'(pos)]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
      pos = wrap_inc(pos, NUM_DEV);
    end
  end

endmodule

// File: rtl/ice_sl_arbiter.sv
// Grant-holding arbiter for the shared ICE sl_* bus; grant appears 1 cycle after a pick, one idle cycle between owners.
// Owner holds until it drops its request; dev_enable removal (or the ICE_ARB_WATCHDOG_EN hold limit) forces release.
module ice_sl_arbiter
  import ice_sl_arbiter_pkg::*;
#(
  parameter int NUM_DEV  = 7,
  parameter int HOLD_MAX = 4096,
  parameter int IDX_W    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_DEV-1:0]     dev_enable,
  input  logic                   prio_mode,
  ice_sl_arbiter_if.slave        arb_if,
  output logic                   arb_abort,
  output logic [ABORT_CNT_W-1:0] abort_count
);

  arb_state_e               state_q, state_d;
  logic [NUM_DEV-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic                     busy_q, busy_d;
  logic                     abort_q, abort_d;
  logic [ABORT_CNT_W-1:0]   abort_cnt_q, abort_cnt_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_DEV-1:0]       penalty_q, penalty_d;

  logic [NUM_DEV-1:0]       elig;
  logic                     pick_found;
  logic [IDX_W-1:0]         pick_idx;
  logic                     hold_expired;

  assign elig = arb_if.sl_arb_request & dev_enable & ~penalty_q;

  ice_sl_arbiter_pick #(
    .NUM_DEV (NUM_DEV),
    .IDX_W   (IDX_W)
  ) u_pick (
    .elig      (elig),
    .rr_ptr    (rr_ptr_q),
    .prio_mode (prio_mode),
    .found     (pick_found),
    .idx       (pick_idx)
  );

`ifdef ICE_ARB_WATCHDOG_EN
  localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  assign hold_expired = (hold_cnt_q == HOLD_W'(HOLD_MAX - 1));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q != ST_OWN) hold_cnt_d = '0;
    else                   hold_cnt_d = hold_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    abort_d     = 1'b0;
    abort_cnt_d = abort_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    // A penalised device must show its request low for a cycle before it may compete again.
    penalty_d   = penalty_q & arb_if.sl_arb_request;

    case (state_q)
      ST_OWN: begin
        if (!dev_enable[owner_q] || hold_expired || !arb_if.sl_arb_request[owner_q]) begin
          state_d  = ST_GAP;
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = IDX_W'(wrap_inc(int'(owner_q), NUM_DEV));
          if (!dev_enable[owner_q] || hold_expired) begin
            abort_d            = 1'b1;
            penalty_d[owner_q] = 1'b1;
            if (abort_cnt_q != ABORT_CNT_MAX) abort_cnt_d = abort_cnt_q + 1'b1;
          end
        end
      end
      // GAP is the turnaround cycle itself; the pick made during it lands one edge later.
      ST_IDLE, ST_GAP: begin
        state_d = ST_IDLE;
        if (pick_found) begin
          state_d = ST_OWN;
          grant_d = NUM_DEV'(1) << pick_idx;
          owner_d = pick_idx;
          busy_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
      abort_cnt_q <= '0;
      rr_ptr_q    <= '0;
      penalty_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      abort_q     <= abort_d;
      abort_cnt_q <= abort_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      penalty_q   <= penalty_d;
    end
  end

  assign arb_if.sl_arb_grant = grant_q;
  assign arb_if.sl_busy      = busy_q;
  assign arb_if.sl_owner     = owner_q;
  assign arb_abort           = abort_q;
  assign abort_count         = abort_cnt_q;

endmodule

// File: tb/tb_ice_sl_arbiter.sv
// Directed bench for ice_sl_arbiter: fixed/RR picks, forced release, penalty, reset, saturation, optional watchdog.
module tb_ice_sl_arbiter;

  logic       clk;
  logic       reset;
  logic [6:0] dev_enable;
  logic       prio_mode;
  logic       arb_abort;
  logic [7:0] abort_count;

  int n_checks;
  int n_pass;

  ice_sl_arbiter_if #(.NUM_DEV(7), .IDX_W(3)) bus ();

  ice_sl_arbiter #(
    .NUM_DEV  (7),
    .HOLD_MAX (16),
    .IDX_W    (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dev_enable  (dev_enable),
    .prio_mode   (prio_mode),
    .arb_if      (bus),
    .arb_abort   (arb_abort),
    .abort_count (abort_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dev_enable = 7'h7F;
    prio_mode = 1'b0;
    bus.sl_arb_request = 7'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0) $display("FAIL reset_grant: got %b want %b", bus.sl_arb_grant, 7'b0); else n_pass++;
    n_checks++; if (bus.sl_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.sl_busy); else n_pass++;
    n_checks++; if (bus.sl_owner !== 3'd0) $display("FAIL reset_owner: got %0d want 0", bus.sl_owner); else n_pass++;
    n_checks++; if (arb_abort !== 1'b0) $display("FAIL reset_abort: got %b want 0", arb_abort); else n_pass++;
    n_checks++; if (abort_count !== 8'd0) $display("FAIL reset_abort_count: got %0d want 0", abort_count); else n_pass++;
  endtask

  task automatic test_fixed();
    do_reset();
    prio_mode = 1'b0;
    bus.sl_arb_request = 7'b0100110;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0000010) $display("FAIL fixed_first_grant: got %b want %b", bus.sl_arb_grant, 7'b0000010); else n_pass++;
    n_checks++; if (bus.sl_owner !== 3'd1) $display("FAIL fixed_first_owner: got %0d want 1", bus.sl_owner); else n_pass++;
    n_checks++; if (bus.sl_busy !== 1'b1) $display("FAIL fixed_busy: got %b want 1", bus.sl_busy); else n_pass++;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0000010) $display("FAIL fixed_hold: got %b want %b", bus.sl_arb_grant, 7'b0000010); else n_pass++;
    bus.sl_arb_request = 7'b0100100;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0) $display("FAIL fixed_gap_grant: got %b want %b", bus.sl_arb_grant, 7'b0); else n_pass++;
    n_checks++; if (bus.sl_busy !== 1'b0) $display("FAIL fixed_gap_busy: got %b want 0", bus.sl_busy); else n_pass++;
    n_checks++; if (bus.sl_owner !== 3'd1) $display("FAIL fixed_owner_retained: got %0d want 1", bus.sl_owner); else n_pass++;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0000100) $display("FAIL fixed_second_grant: got %b want %b", bus.sl_arb_grant, 7'b0000100); else n_pass++;
    bus.sl_arb_request = 7'b0;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [6:0] exp_grant;
    do_reset();
    prio_mode = 1'b1;
    bus.sl_arb_request = 7'h7F;
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_grant = 7'b1 << (i % 7);
      n_checks++; if (bus.sl_arb_grant !== exp_grant) $display("FAIL rr_grant_%0d: got %b want %b", i, bus.sl_arb_grant, exp_grant); else n_pass++;
      tick();
      tick();
      bus.sl_arb_request = bus.sl_arb_request & ~exp_grant;
      tick();
      n_checks++; if (bus.sl_arb_grant !== 7'b0) $display("FAIL rr_gap_%0d: got %b want %b", i, bus.sl_arb_grant, 7'b0); else n_pass++;
      bus.sl_arb_request = 7'h7F;
      tick();
    end
    bus.sl_arb_request = 7'b0;
    prio_mode = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_enable_abort();
    do_reset();
    bus.sl_arb_request = 7'b0100000;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0100000) $display("FAIL abort_initial_grant: got %b want %b", bus.sl_arb_grant, 7'b0100000); else n_pass++;
    dev_enable = 7'b1011111;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0) $display("FAIL abort_grant_drop: got %b want %b", bus.sl_arb_grant, 7'b0); else n_pass++;
    n_checks++; if (arb_abort !== 1'b1) $display("FAIL abort_pulse: got %b want 1", arb_abort); else n_pass++;
    n_checks++; if (abort_count !== 8'd1) $display("FAIL abort_count_one: got %0d want 1", abort_count); else n_pass++;
    dev_enable = 7'h7F;
    tick();
    n_checks++; if (arb_abort !== 1'b0) $display("FAIL abort_pulse_width: got %b want 0", arb_abort); else n_pass++;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0) $display("FAIL penalty_blocks_regrant: got %b want %b", bus.sl_arb_grant, 7'b0); else n_pass++;
    bus.sl_arb_request = 7'b0;
    tick();
    bus.sl_arb_request = 7'b0100000;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0100000) $display("FAIL penalty_cleared_regrant: got %b want %b", bus.sl_arb_grant, 7'b0100000); else n_pass++;
    bus.sl_arb_request = 7'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    bus.sl_arb_request = 7'b0001000;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0001000) $display("FAIL midrst_pre_grant: got %b want %b", bus.sl_arb_grant, 7'b0001000); else n_pass++;
    n_checks++; if (abort_count !== 8'd1) $display("FAIL midrst_pre_count: got %0d want 1", abort_count); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0) $display("FAIL midrst_grant: got %b want %b", bus.sl_arb_grant, 7'b0); else n_pass++;
    n_checks++; if (bus.sl_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.sl_busy); else n_pass++;
    n_checks++; if (abort_count !== 8'd0) $display("FAIL midrst_count: got %0d want 0", abort_count); else n_pass++;
    n_checks++; if (bus.sl_owner !== 3'd0) $display("FAIL midrst_owner: got %0d want 0", bus.sl_owner); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0001000) $display("FAIL midrst_idle_regrant: got %b want %b", bus.sl_arb_grant, 7'b0001000); else n_pass++;
    bus.sl_arb_request = 7'b0;
    tick();
    tick();
  endtask

  task automatic test_abort_saturation();
    int misses;
    misses = 0;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      bus.sl_arb_request = 7'b0000001;
      dev_enable = 7'h7F;
      tick();
      if (bus.sl_arb_grant !== 7'b0000001) misses++;
      dev_enable = 7'h7E;
      tick();
      bus.sl_arb_request = 7'b0;
      dev_enable = 7'h7F;
      tick();
      if (i == 253) begin
        n_checks++; if (abort_count !== 8'hFE) $display("FAIL sat_count_254: got %0d want 254", abort_count); else n_pass++;
      end
    end
    n_checks++; if (misses !== 0) $display("FAIL sat_grant_misses: got %0d want 0", misses); else n_pass++;
    n_checks++; if (abort_count !== 8'hFF) $display("FAIL sat_count_hold: got %0d want 255", abort_count); else n_pass++;
  endtask

`ifdef ICE_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int held;
    held = 0;
    do_reset();
    bus.sl_arb_request = 7'b0000100;
    tick();
    for (int i = 0; i < 15; i++) begin
      if (bus.sl_arb_grant === 7'b0000100) held++;
      tick();
    end
    if (bus.sl_arb_grant === 7'b0000100) held++;
    n_checks++; if (held !== 16) $display("FAIL wd_hold_cycles: got %0d want 16", held); else n_pass++;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0) $display("FAIL wd_revoke: got %b want %b", bus.sl_arb_grant, 7'b0); else n_pass++;
    n_checks++; if (arb_abort !== 1'b1) $display("FAIL wd_abort: got %b want 1", arb_abort); else n_pass++;
    tick();
    tick();
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0) $display("FAIL wd_no_regrant: got %b want %b", bus.sl_arb_grant, 7'b0); else n_pass++;
    bus.sl_arb_request = 7'b0;
    tick();
    bus.sl_arb_request = 7'b0000100;
    tick();
    n_checks++; if (bus.sl_arb_grant !== 7'b0000100) $display("FAIL wd_regrant: got %b want %b", bus.sl_arb_grant, 7'b0000100); else n_pass++;
    bus.sl_arb_request = 7'b0;
    tick();
    tick();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_enable_abort();
    test_reset_mid_grant();
`ifdef ICE_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    test_abort_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
